// File: rtl/keypad_char_loader.sv
// Scans and debounces a 4x4 active-low key matrix; each fresh single-key press becomes one
// character write (data, char_position, load). Optional auto-repeat: KEYPAD_AUTOREPEAT_EN.
module keypad_char_loader #(
   parameter logic [23:0] SCAN_DIV        = 24'd2_500,
   parameter logic [3:0]  DEBOUNCE_FRAMES = 4'd3,
   parameter logic [7:0]  REPEAT_FRAMES   = 8'd40
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] row_in,
   input  logic       clear_pos,
   output logic [3:0] col_out,
   output logic [3:0] data,
   output logic [1:0] char_position,
   output logic       load,
   output logic       key_down,
   output logic [1:0] fsm_state_o
);
   typedef enum logic [1:0] {RELEASED = 2'd0, EMIT = 2'd1, HELD = 2'd2} state_t;

   logic [3:0]  row_meta_q, rows_s_q;
   logic [23:0] div_q;
   logic [1:0]  col_q;
   logic [15:0] frame_q;
   logic [15:0] snapshot_q, snapshot_d;
   logic [3:0]  match_cnt_q, match_cnt_d;
   logic [15:0] stable_q, stable_d;
   state_t      state_q;
   logic [1:0]  pos_q, char_pos_q;
   logic [3:0]  data_q;
   logic        load_q;
   logic        tick, frame_end, one_key;
   logic [3:0]  key_code;

   assign tick      = (div_q == SCAN_DIV - 24'd1);
   assign frame_end = tick && (col_q == 2'd3);

   // Column 3 is sampled on the very tick that closes the frame, so it bypasses frame_q.
   always_comb begin
      snapshot_d        = frame_q;
      snapshot_d[15:12] = ~rows_s_q;
      match_cnt_d       = match_cnt_q;
      stable_d          = stable_q;
      if (frame_end) begin
         if (snapshot_d == snapshot_q)
            match_cnt_d = (match_cnt_q == 4'd15) ? 4'd15 : match_cnt_q + 4'd1;
         else
            match_cnt_d = 4'd1;
         if (match_cnt_d == DEBOUNCE_FRAMES)
            stable_d = snapshot_d;
      end
   end

   assign one_key = (stable_d != 16'd0) && ((stable_d & (stable_d - 16'd1)) == 16'd0);

   // Bit index is 4*col+row; the emitted code is row*4+col.
   always_comb begin
      key_code = 4'd0;
      for (int i = 0; i < 16; i++)
         if (stable_d[i]) key_code = {i[1:0], i[3:2]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_meta_q  <= 4'hF;
         rows_s_q    <= 4'hF;
         div_q       <= 24'd0;
         col_q       <= 2'd0;
         frame_q     <= 16'd0;
         snapshot_q  <= 16'd0;
         match_cnt_q <= 4'd0;
         stable_q    <= 16'd0;
      end else begin
         row_meta_q <= row_in;
         rows_s_q   <= row_meta_q;
         if (tick) begin
            div_q                      <= 24'd0;
            col_q                      <= col_q + 2'd1;
            frame_q[{col_q, 2'b00} +: 4] <= ~rows_s_q;
         end else begin
            div_q <= div_q + 24'd1;
         end
         if (frame_end) snapshot_q <= snapshot_d;
         match_cnt_q <= match_cnt_d;
         stable_q    <= stable_d;
      end
   end

`ifdef KEYPAD_AUTOREPEAT_EN
   logic [7:0] rep_cnt_q;
`else
   logic unused_repeat_frames;
   assign unused_repeat_frames = ^REPEAT_FRAMES;
`endif

   // load is a one-cycle valid with no ready: data and char_position are valid while it is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RELEASED;
         pos_q      <= 2'd0;
         char_pos_q <= 2'd0;
         data_q     <= 4'd0;
         load_q     <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
         rep_cnt_q  <= 8'd0;
`endif
      end else begin
         load_q <= 1'b0;
         if (state_q == EMIT) begin
            char_pos_q <= clear_pos ? 2'd0 : char_pos_q;
            pos_q      <= clear_pos ? 2'd1 : pos_q + 2'd1;
            state_q    <= HELD;
         end else begin
            if (clear_pos) pos_q <= 2'd0;
            if (frame_end) begin
               case (state_q)
                  RELEASED: begin
`ifdef KEYPAD_AUTOREPEAT_EN
                     rep_cnt_q <= 8'd0;
`endif
                     if (one_key) begin
                        state_q    <= EMIT;
                        load_q     <= 1'b1;
                        data_q     <= key_code;
                        char_pos_q <= clear_pos ? 2'd0 : pos_q;
                     end else if (stable_d != 16'd0) begin
                        state_q <= HELD;
                     end
                  end
                  HELD: begin
                     if (stable_d == 16'd0) begin
                        state_q <= RELEASED;
                     end
`ifdef KEYPAD_AUTOREPEAT_EN
                     else if (stable_d != stable_q) begin
                        rep_cnt_q <= 8'd0;
                     end else if (one_key) begin
                        if (rep_cnt_q + 8'd1 == REPEAT_FRAMES) begin
                           state_q    <= EMIT;
                           load_q     <= 1'b1;
                           data_q     <= key_code;
                           char_pos_q <= clear_pos ? 2'd0 : pos_q;
                           rep_cnt_q  <= 8'd0;
                        end else begin
                           rep_cnt_q <= rep_cnt_q + 8'd1;
                        end
                     end
`endif
                  end
                  default: state_q <= RELEASED;
               endcase
            end
         end
      end
   end

   assign col_out       = ~(4'b0001 << col_q);
   assign data          = data_q;
   assign load          = load_q;
   assign char_position = (state_q == EMIT && clear_pos) ? 2'd0 : char_pos_q;
   assign key_down      = |stable_q;
   assign fsm_state_o   = state_q;
endmodule

// File: tb/tb_keypad_char_loader.sv
// Bench for keypad_char_loader: a key-matrix model drives row_in, loads are collected and
// compared against expectations derived from press sequences.
module tb_keypad_char_loader;
   localparam int FRAME = 16;
   localparam int REP   = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] row_in;
   logic       clear_pos;
   logic [3:0] col_out, data;
   logic [1:0] char_position, fsm_state;
   logic       load, key_down;

   logic [15:0] keys_q = 16'd0;
   logic        bounce_en = 1'b0, bounce_val = 1'b1;
   logic        clr_on_load = 1'b0, clear_pos_r = 1'b0;

   int checks = 0, failures = 0;
   int pos_m = 0;
   logic [5:0] exp_q[$];
   logic [5:0] obs_q[$];
   logic [5:0] last_exp;
   logic       prev_load = 1'b0;

   typedef struct packed {
      logic [3:0] key;
      logic [3:0] exp_data;
      logic [1:0] exp_pos;
   } wrap_vec_t;
   wrap_vec_t wrap_tbl[5];

   keypad_char_loader #(.SCAN_DIV(24'd4), .DEBOUNCE_FRAMES(4'd2), .REPEAT_FRAMES(8'd3)) dut (
      .clk(clk), .rst_n(rst_n), .row_in(row_in), .clear_pos(clear_pos),
      .col_out(col_out), .data(data), .char_position(char_position), .load(load),
      .key_down(key_down), .fsm_state_o(fsm_state)
   );

   always #5 clk = ~clk;

   // Ideal switch matrix: a pressed key pulls its row low while its column is driven low.
   always_comb begin
      row_in = 4'hF;
      for (int k = 0; k < 16; k++)
         if (keys_q[k] && !col_out[k % 4]) row_in[k / 4] = 1'b0;
      if (bounce_en) row_in[0] = bounce_val;
   end

   assign clear_pos = clear_pos_r | (clr_on_load & load);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && load) begin
         check("no_back_to_back_load", {31'd0, prev_load}, 32'd0);
         obs_q.push_back({data, char_position});
      end
      prev_load <= rst_n && load;
   end

   function automatic int exp_loads(input int hold_frames);
`ifdef KEYPAD_AUTOREPEAT_EN
      return 1 + (hold_frames - 1) / REP;
`else
      return 1;
`endif
   endfunction

   task automatic expect_press(input logic [3:0] key, input int hold_frames);
      for (int n = 0; n < exp_loads(hold_frames); n++) begin
         last_exp = {key, pos_m[1:0]};
         exp_q.push_back(last_exp);
         pos_m = (pos_m + 1) % 4;
      end
   endtask

   task automatic press(input logic [15:0] mask, input int frames);
      keys_q = mask;
      repeat (frames * FRAME) @(negedge clk);
      keys_q = 16'd0;
   endtask

   task automatic gap_and_check_idle(input string name, input int frames);
      repeat (frames * FRAME) @(negedge clk);
      #1 check({name, "_key_down_idle"}, {31'd0, key_down}, 32'd0);
   endtask

   task automatic compare_loads(input string name);
      logic [5:0] o, e;
      #1 check({name, "_load_count"}, obs_q.size(), exp_q.size());
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         check({name, "_data"}, {28'd0, o[5:2]}, {28'd0, e[5:2]});
         check({name, "_pos"}, {30'd0, o[1:0]}, {30'd0, e[1:0]});
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      keys_q = 16'd0;
      bounce_en = 1'b0;
      clear_pos_r = 1'b0;
      clr_on_load = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      obs_q.delete();
      exp_q.delete();
      pos_m = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] col_seq[4];
      int kind, k1, k2, waited;
      logic seen;
      col_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      wrap_tbl[0] = '{4'h0, 4'h0, 2'd0};
      wrap_tbl[1] = '{4'h5, 4'h5, 2'd1};
      wrap_tbl[2] = '{4'hA, 4'hA, 2'd2};
      wrap_tbl[3] = '{4'hF, 4'hF, 2'd3};
      wrap_tbl[4] = '{4'h3, 4'h3, 2'd0};

      // Reset values and column scan order.
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_col_out", {28'd0, col_out}, 32'b1110);
      check("rst_load", {31'd0, load}, 32'd0);
      check("rst_data", {28'd0, data}, 32'd0);
      check("rst_char_position", {30'd0, char_position}, 32'd0);
      check("rst_key_down", {31'd0, key_down}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1 check("col_scan", {28'd0, col_out}, {28'd0, col_seq[i % 4]});
         repeat (4) @(negedge clk);
      end

      // Single press of row 2 / col 1 held for 6 frames.
      do_reset();
      expect_press(4'h9, 6);
      press(16'd1 << 9, 6);
      #1 check("single_key_down_held", {31'd0, key_down}, 32'd1);
      gap_and_check_idle("single", 4);
      check("single_data_hold", {28'd0, data}, {28'd0, last_exp[5:2]});
      check("single_pos_hold", {30'd0, char_position}, {30'd0, last_exp[1:0]});
      compare_loads("single");

      // Position wrap over a table of presses.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back({wrap_tbl[i].exp_data, wrap_tbl[i].exp_pos});
         press(16'd1 << wrap_tbl[i].key, 3);
         gap_and_check_idle("wrap", 5);
         compare_loads("wrap");
      end
      check("wrap_data_hold", {28'd0, data}, 32'h3);
      check("wrap_pos_hold", {30'd0, char_position}, 32'd0);

      // Row 0 bouncing every 3 clocks for 2 frames, aligned to the start of a scan frame.
      waited = 0;
      while (col_out !== 4'b0111 && waited < 64) begin @(negedge clk); waited++; end
      while (col_out !== 4'b1110 && waited < 64) begin @(negedge clk); waited++; end
      check("bounce_align_found", {31'd0, (waited < 64)}, 32'd1);
      bounce_en = 1'b1;
      for (int t = 0; t < 2 * FRAME; t++) begin
         bounce_val = ((t / 3) % 2) != 0;
         @(negedge clk);
      end
      bounce_en = 1'b0;
      gap_and_check_idle("bounce", 4);
      compare_loads("bounce");

      // Two keys together: no write, but key_down.
      press(16'h0006, 4);
      #1 check("ghost_key_down", {31'd0, key_down}, 32'd1);
      gap_and_check_idle("ghost", 5);
      compare_loads("ghost");

      // clear_pos during the EMIT cycle of the third press.
      do_reset();
      expect_press(4'h4, 3); press(16'd1 << 4, 3); gap_and_check_idle("clr", 5);
      expect_press(4'h6, 3); press(16'd1 << 6, 3); gap_and_check_idle("clr", 5);
      clr_on_load = 1'b1;
      pos_m = 0;
      expect_press(4'hB, 3); press(16'd1 << 11, 3); gap_and_check_idle("clr", 5);
      clr_on_load = 1'b0;
      check("clr_model_pos", pos_m, 32'd1);
      expect_press(4'hC, 3); press(16'd1 << 12, 3); gap_and_check_idle("clr", 5);
      compare_loads("clear_pos");

      // Long hold of key 7.
      do_reset();
      expect_press(4'h7, 12);
      press(16'd1 << 7, 12);
      gap_and_check_idle("hold12", 5);
      compare_loads("hold12");

      // Reset while load is high: the write is abandoned and pos restarts at 0.
      do_reset();
      keys_q = 16'd1 << 5;
      seen = 1'b0;
      for (int c = 0; c < 6 * FRAME && !seen; c++) begin
         @(posedge clk);
         #1 seen = load;
      end
      check("mid_emit_load_seen", {31'd0, seen}, 32'd1);
      rst_n = 1'b0;
      keys_q = 16'd0;
      #1 check("mid_emit_load_async_drop", {31'd0, load}, 32'd0);
      check("mid_emit_col_out", {28'd0, col_out}, 32'b1110);
      @(negedge clk);
      rst_n = 1'b1;
      check("mid_emit_no_write", obs_q.size(), 32'd0);
      obs_q.delete();
      pos_m = 0;
      expect_press(4'h2, 3); press(16'd1 << 2, 3); gap_and_check_idle("mid", 5);
      compare_loads("after_mid_reset");

      // Randomized presses against the position model.
      do_reset();
      for (int it = 0; it < 12; it++) begin
         kind = $urandom_range(0, 4);
         if (kind == 0) begin
            k1 = $urandom_range(0, 15);
            k2 = (k1 + $urandom_range(1, 15)) % 16;
            press((16'd1 << k1) | (16'd1 << k2), 4);
         end else begin
            if (kind == 1) begin
               clear_pos_r = 1'b1;
               @(negedge clk);
               clear_pos_r = 1'b0;
               pos_m = 0;
            end
            k1 = $urandom_range(0, 15);
            expect_press(k1[3:0], 3);
            press(16'd1 << k1, 3);
         end
         #1 check("rand_key_down_pressed", {31'd0, key_down}, 32'd1);
         gap_and_check_idle("rand", 5);
         compare_loads("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/keypad_char_loader.md
# keypad_char_loader

Scans a 4x4 active-low key matrix, debounces it, and turns each fresh single-key press into one character write: a 4-bit data, 2-bit char_position, 1-cycle load strobe. It is the writer for the character-load interface of the multiplexed LED display: its data, char_position and load outputs connect directly to the display's loader inputs. Each key press fills the next of the four character slots, wrapping around.

## Interface
- SCAN_DIV, default 24'd2_500: clock cycles per column dwell; legal range is 4 or more.
- DEBOUNCE_FRAMES, default 4'd3: number of consecutive identical full-matrix frames needed to accept a matrix state; legal range 1–15.
- REPEAT_FRAMES, default 8'd40: stable frames between auto-repeat emissions; only used with KEYPAD_AUTOREPEAT_EN.
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- row_in  input  4  matrix rows, active-low, externally pulled up, asynchronous to clk.
- clear_pos  input  1  synchronous; sets the next char_position to 0.
- col_out  output  4  column drive, active-low, one-hot-low.
- data  output  4  key code of the last emitted key.
- char_position  output  2  slot of the last emitted key.
- load  output  1  one-cycle write strobe.
- key_down  output  1  high while the debounced matrix has at least one key pressed.

## Operation
- Input sync: row_in passes through a 2-flop synchronizer to give rows_s.
- Scan:
  - A divider counts 0..SCAN_DIV-1.
  - When divider = SCAN_DIV-1 (a tick), ~rows_s is stored into frame bits [4*col+3:4*col] and col advances 0→1→2→3→0.
  - col_out = ~(4'b0001 << col).
- Frame end: the tick leaving col 3 completes a 16-bit frame snapshot, bit index 4*col+row, 1 = pressed.
- Debounce:
  - If the snapshot equals the previous snapshot, match_cnt increments, saturating at 15. Otherwise match_cnt = 1.
  - When match_cnt reaches DEBOUNCE_FRAMES, stable <= snapshot.
- Key code = {row[1:0], col[1:0]}, i.e. row*4+col, taken from the single set bit of stable.
- FSM, states RELEASED, EMIT, HELD; evaluated once per frame end, after the stable update:
  - RELEASED, stable has exactly one bit set → EMIT.
  - RELEASED, stable has two or more bits set → HELD, no emission (ghosting guard).
  - RELEASED, stable = 0 → stay in RELEASED.
  - EMIT lasts exactly one clk cycle:
    - load = 1, data = key code, char_position = pos.
    - Then pos <= pos+1 mod 4, and the FSM goes to HELD.
  - HELD, stable = 0 → RELEASED. Any other change of stable in HELD, including switching to a different single key, emits nothing.
- key_down = |stable.
- Position:
  - pos resets to 0 and wraps 3→0.
  - clear_pos has priority: if asserted in the EMIT cycle, the write uses char_position = 0 and pos becomes 1. Otherwise pos becomes 0.
- data and char_position hold their values between loads.

## Timing
- Reset values: col_out = 4'b1110; data = 0; char_position = 0; load = 0; key_down = 0; FSM = RELEASED; pos = 0; divider = 0; col = 0; snapshot = 0; stable = 0; match_cnt = 0.
- Frame period = 4*SCAN_DIV cycles.
- Latency: from the frame end on which match_cnt reaches DEBOUNCE_FRAMES, stable updates that cycle and load asserts on the next cycle.
- Worst-case press-to-load ≈ (DEBOUNCE_FRAMES+1) frames + 3 cycles (sync + FSM).
- load never asserts on two consecutive cycles. Minimum spacing between loads is one frame.
- rst_n asserted mid-scan or mid-EMIT: all state clears immediately, load drops asynchronously, and no write completes.
- A row glitch shorter than one frame never reaches stable when DEBOUNCE_FRAMES ≥ 2.

## Configuration
- KEYPAD_AUTOREPEAT_EN defined:
  - In HELD with exactly one stable key, a repeat counter increments per frame end.
  - When it reaches REPEAT_FRAMES, the FSM re-enters EMIT with the same code and the counter clears.
  - The counter clears on any change of stable.
- KEYPAD_AUTOREPEAT_EN undefined: the repeat counter logic is absent, and one press gives exactly one load no matter how long the key is held.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_FRAMES=2.
- Reset: hold rst_n=0 → col_out=1110, load=0, data=0, char_position=0. Release reset → col_out cycles 1110, 1101, 1011, 0111, changing every 4 clocks.
- Single press: key row 2 / col 1 held for 6 frames → exactly one load pulse with data=4'h9, char_position=0. key_down=1 until 3 frames after release.
- Wrap: press then release keys 0, 5, A, F, 3 in sequence → char_position 0, 1, 2, 3, 0 and data 0, 5, A, F, 3, each on a one-cycle load.
- Bounce/ghost: toggle row 0 every 3 clocks for 2 frames → no load. Press keys 1 and 2 together → no load, key_down=1.
- clear_pos: after two emissions (pos=2), assert clear_pos in the EMIT cycle of the next press → char_position=0, and the following press uses char_position=1.
- Autorepeat (macro on, REPEAT_FRAMES=3): hold key 7 for 12 frames → the first load, then further loads every 3 frames, all with data=7 and char_position incrementing. With the macro off → a single load.
